// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM access arbiter.
//   state_e : arbiter operating phase (BOOT -> RUN -> HALT).
//   tag_e   : owner of a read slot in the return pipeline.
//   HALT_OPCODE : terminator word; ends boot when loaded, halts the CPU when fetched.
package ram_arb_pkg;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2
  } tag_e;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: two-requester grant picker (instruction fetch vs data access).
// Optional feature macro: RAM_ARB_RR_EN
//   defined   : conflicts resolve round-robin; the pointer moves to the winner
//               only on a contended grant; after reset Dm wins the first conflict.
//   undefined : fixed priority, Dm always beats If (pure combinational).
// Ports:
//   i_clk, i_rst_n : clock / async active-low reset (round-robin build only)
//   i_en           : grants allowed this cycle
//   i_if_req       : fetch request
//   i_dm_req       : data request
//   o_if_gnt       : fetch granted (combinational)
//   o_dm_gnt       : data granted (combinational)
module ram_arb_pick (
`ifdef RAM_ARB_RR_EN
  input  logic i_clk,
  input  logic i_rst_n,
`endif
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_if_gnt,
  output logic o_dm_gnt
);

`ifdef RAM_ARB_RR_EN
  // 1 = If won the last conflict, so Dm is favoured next time.
  logic r_if_last;
  logic w_if_wins;

  assign w_if_wins = i_if_req & (~i_dm_req | ~r_if_last);
  assign o_if_gnt  = i_en & w_if_wins;
  assign o_dm_gnt  = i_en & i_dm_req & ~w_if_wins;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_last <= 1'b1;
    end else if (i_en && i_if_req && i_dm_req) begin
      r_if_last <= w_if_wins;
    end
  end
`else
  assign o_dm_gnt = i_en & i_dm_req;
  assign o_if_gnt = i_en & i_if_req & ~i_dm_req;
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: owner of the single port of the program/data RAM.
// Boot phase gives the loader exclusive write access until a HALT_OPCODE word
// or the last address is written; the port is then shared between CPU fetch
// (If) and data access (Dm); fetching HALT_OPCODE stops the CPU until reset.
// Optional feature macro: RAM_ARB_RR_EN (round-robin If/Dm conflicts,
// otherwise Dm has fixed priority).
//
// Handshake: a requester raises Req with Addr/Data and holds them stable until
// the cycle Gnt is high; Gnt is combinational from Req and state and means the
// access is taken at the next rising edge. Read data comes back exactly two
// cycles after the grant cycle as a one-cycle Valid pulse with its data.
//
// Ports:
//   Clock, Reset_n            : clock, async active-low reset
//   LdReq/LdAddr/LdData/LdGnt : loader write channel (BOOT only)
//   IfReq/IfAddr/IfGnt        : fetch request; IfData/IfValid fetch return
//   DmReq/DmWe/DmAddr/DmWData/DmGnt : data request; DmRData/DmValid read return
//   RamAddr/RamD/RamWe        : registered RAM port controls
//   RamQ                      : synchronous RAM read data (1 cycle after RamAddr)
//   BootDone                  : program loaded (sticky until reset)
//   CpuRun                    : CPU may execute
//   DbgState                  : current arbiter phase (state_e encoding)
module ram_access_arbiter #(
  parameter int              AW          = 5,
  parameter int              DW          = 8,
  parameter logic [DW-1:0]   HALT_OPCODE = DW'(ram_arb_pkg::HALT_OPCODE)
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          LdReq,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdData,
  output logic          LdGnt,
  input  logic          IfReq,
  input  logic [AW-1:0] IfAddr,
  output logic          IfGnt,
  output logic [DW-1:0] IfData,
  output logic          IfValid,
  input  logic          DmReq,
  input  logic          DmWe,
  input  logic [AW-1:0] DmAddr,
  input  logic [DW-1:0] DmWData,
  output logic          DmGnt,
  output logic [DW-1:0] DmRData,
  output logic          DmValid,
  output logic [AW-1:0] RamAddr,
  output logic [DW-1:0] RamD,
  output logic          RamWe,
  input  logic [DW-1:0] RamQ,
  output logic          BootDone,
  output logic          CpuRun,
  output logic [1:0]    DbgState
);

  import ram_arb_pkg::*;

  state_e        r_state;
  logic          r_boot_done;
  logic          r_cpu_run;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_d;
  logic          r_ram_we;
  // Read-tag pipeline: r_tag1 = access on the RAM port now, r_tag2 = data on RamQ now.
  tag_e          r_tag1;
  tag_e          r_tag2;

  logic          w_ld_gnt;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_run;
  logic          w_if_valid;
  logic          w_dm_valid;
  logic          w_boot_last;

  assign w_run    = (r_state == RUN);
  assign w_ld_gnt = (r_state == BOOT) & LdReq;

  ram_arb_pick u_pick (
`ifdef RAM_ARB_RR_EN
    .i_clk    (Clock),
    .i_rst_n  (Reset_n),
`endif
    .i_en     (w_run),
    .i_if_req (IfReq),
    .i_dm_req (DmReq),
    .o_if_gnt (w_if_gnt),
    .o_dm_gnt (w_dm_gnt)
  );

  // The terminating loader write still goes to the RAM; the phase change follows it.
  assign w_boot_last = (LdData == HALT_OPCODE) || (LdAddr == {AW{1'b1}});

  assign w_if_valid = (r_tag2 == TAG_IF);
  assign w_dm_valid = (r_tag2 == TAG_DM);

  // Phase FSM with registered status outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= BOOT;
      r_boot_done <= 1'b0;
      r_cpu_run   <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          if (w_ld_gnt && w_boot_last) begin
            r_state     <= RUN;
            r_boot_done <= 1'b1;
            r_cpu_run   <= 1'b1;
          end
        end
        RUN: begin
          if (w_if_valid && (RamQ == HALT_OPCODE)) begin
            r_state   <= HALT;
            r_cpu_run <= 1'b0;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state     <= BOOT;
          r_boot_done <= 1'b0;
          r_cpu_run   <= 1'b0;
        end
      endcase
    end
  end

  // RAM port registers and read-tag pipeline. Address and write data hold on
  // idle cycles; write data only changes on writes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ram_addr <= '0;
      r_ram_d    <= '0;
      r_ram_we   <= 1'b0;
      r_tag1     <= TAG_NONE;
      r_tag2     <= TAG_NONE;
    end else begin
      r_ram_we <= 1'b0;
      if (w_ld_gnt) begin
        r_ram_addr <= LdAddr;
        r_ram_d    <= LdData;
        r_ram_we   <= 1'b1;
      end else if (w_if_gnt) begin
        r_ram_addr <= IfAddr;
      end else if (w_dm_gnt) begin
        r_ram_addr <= DmAddr;
        if (DmWe) begin
          r_ram_d  <= DmWData;
          r_ram_we <= 1'b1;
        end
      end

      if (w_if_gnt) begin
        r_tag1 <= TAG_IF;
      end else if (w_dm_gnt && !DmWe) begin
        r_tag1 <= TAG_DM;
      end else begin
        r_tag1 <= TAG_NONE;
      end
      r_tag2 <= r_tag1;
    end
  end

  assign LdGnt    = w_ld_gnt;
  assign IfGnt    = w_if_gnt;
  assign DmGnt    = w_dm_gnt;
  // Return data is gated so the buses read 0 whenever nothing is returned.
  assign IfValid  = w_if_valid;
  assign IfData   = w_if_valid ? RamQ : '0;
  assign DmValid  = w_dm_valid;
  assign DmRData  = w_dm_valid ? RamQ : '0;
  assign RamAddr  = r_ram_addr;
  assign RamD     = r_ram_d;
  assign RamWe    = r_ram_we;
  assign BootDone = r_boot_done;
  assign CpuRun   = r_cpu_run;
  assign DbgState = r_state;

endmodule
